// File: rtl/leaf_link_serdes_if.sv
// Handshake bundle for leaf_link_serdes: leaf message side and physical link side.
// The slave modport is the serdes view; the master modport is the environment view.
interface leaf_link_serdes_if #(
  parameter int unsigned HUB_FIFO_WIDTH = 20,
  parameter int unsigned LINK_WIDTH     = 8
) ();
  logic [HUB_FIFO_WIDTH-1:0] leaf_out_data;
  logic                      leaf_out_valid;
  logic                      leaf_out_ready;
  logic [HUB_FIFO_WIDTH-1:0] leaf_in_data;
  logic                      leaf_in_valid;
  logic                      leaf_in_ready;
  logic [LINK_WIDTH-1:0]     link_tx_data;
  logic                      link_tx_valid;
  logic                      link_tx_last;
  logic                      link_tx_ready;
  logic [LINK_WIDTH-1:0]     link_rx_data;
  logic                      link_rx_valid;
  logic                      link_rx_last;
  logic                      link_rx_ready;

  modport slave (
    input  leaf_out_data, leaf_out_valid,
    output leaf_out_ready,
    output leaf_in_data, leaf_in_valid,
    input  leaf_in_ready,
    output link_tx_data, link_tx_valid, link_tx_last,
    input  link_tx_ready,
    input  link_rx_data, link_rx_valid, link_rx_last,
    output link_rx_ready
  );

  modport master (
    output leaf_out_data, leaf_out_valid,
    input  leaf_out_ready,
    input  leaf_in_data, leaf_in_valid,
    output leaf_in_ready,
    input  link_tx_data, link_tx_valid, link_tx_last,
    output link_tx_ready,
    output link_rx_data, link_rx_valid, link_rx_last,
    input  link_rx_ready
  );
endinterface

// File: rtl/leaf_link_serdes.sv
// Leaf/hub message serdes: buffers leaf words in a small FIFO, sends each as BEATS link beats
// (LSB first), and reassembles incoming beat frames into words with framing-error detection.
module leaf_link_serdes #(
  parameter int unsigned HUB_FIFO_WIDTH = 20,
  parameter int unsigned LINK_WIDTH     = 8,
  parameter int unsigned TX_DEPTH       = 4
) (
  input logic               clk,
  input logic               reset,
  leaf_link_serdes_if.slave bus,
  output logic              busy,
  output logic              rx_frame_error
);
  localparam int unsigned BEATS = (HUB_FIFO_WIDTH + LINK_WIDTH - 1) / LINK_WIDTH;
  localparam int unsigned ShW   = BEATS * LINK_WIDTH;
  localparam int unsigned PtrW  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

  typedef enum logic {TxIdle, TxSend} tx_state_e;
  typedef enum logic {RxCollect, RxHold} rx_state_e;

  logic [HUB_FIFO_WIDTH-1:0] fifo_mem [TX_DEPTH];
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]             fifo_cnt_q;
  logic                      fifo_push, fifo_pop, fifo_empty, fifo_full;

  tx_state_e                 tx_state_q, tx_state_d;
  logic [ShW-1:0]            shift_q, shift_d;
  logic [BeatW-1:0]          beat_q, beat_d;

  rx_state_e                 rx_state_q, rx_state_d;
  logic [ShW-1:0]            rx_buf_q, rx_buf_d;
  logic [BeatW-1:0]          rx_cnt_q, rx_cnt_d;
  logic                      rx_drop_q, rx_drop_d;
  logic                      rx_err_q, rx_err_d;
  logic                      unused_rx_pad;

  // Transmit FIFO; pointers wrap naturally because TX_DEPTH is a power of two.
  assign fifo_full          = fifo_cnt_q == (PtrW + 1)'(TX_DEPTH);
  assign fifo_empty         = fifo_cnt_q == '0;
  assign bus.leaf_out_ready = !fifo_full;
  assign fifo_push          = bus.leaf_out_valid && !fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (fifo_push && !fifo_pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!fifo_push && fifo_pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= bus.leaf_out_data;
  end

  // Serializer: the last-beat acceptance reloads straight from the FIFO to avoid a bubble.
  always_comb begin
    tx_state_d = tx_state_q;
    shift_d    = shift_q;
    beat_d     = beat_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = ShW'(fifo_mem[rd_ptr_q]);
          beat_d     = '0;
          tx_state_d = TxSend;
        end
      end
      TxSend: begin
        if (bus.link_tx_ready) begin
          if (beat_q == LastBeat) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = ShW'(fifo_mem[rd_ptr_q]);
              beat_d   = '0;
            end else begin
              tx_state_d = TxIdle;
            end
          end else begin
            shift_d = shift_q >> LINK_WIDTH;
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      shift_q    <= '0;
      beat_q     <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      shift_q    <= shift_d;
      beat_q     <= beat_d;
    end
  end

  assign bus.link_tx_valid = tx_state_q == TxSend;
  assign bus.link_tx_last  = (tx_state_q == TxSend) && (beat_q == LastBeat);
  assign bus.link_tx_data  = shift_q[LINK_WIDTH-1:0];

  // Assembler: a frame missing its last flag is flushed up to and including the next last beat.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_buf_d   = rx_buf_q;
    rx_cnt_d   = rx_cnt_q;
    rx_drop_d  = rx_drop_q;
    rx_err_d   = rx_err_q;
    case (rx_state_q)
      RxCollect: begin
        if (bus.link_rx_valid) begin
          if (rx_drop_q) begin
            if (bus.link_rx_last) rx_drop_d = 1'b0;
          end else if (rx_cnt_q == LastBeat) begin
            if (bus.link_rx_last) begin
              rx_buf_d[rx_cnt_q*LINK_WIDTH +: LINK_WIDTH] = bus.link_rx_data;
              rx_state_d = RxHold;
            end else begin
              rx_err_d  = 1'b1;
              rx_cnt_d  = '0;
              rx_drop_d = 1'b1;
            end
          end else if (bus.link_rx_last) begin
            rx_err_d = 1'b1;
            rx_cnt_d = '0;
          end else begin
            rx_buf_d[rx_cnt_q*LINK_WIDTH +: LINK_WIDTH] = bus.link_rx_data;
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RxHold: begin
        if (bus.leaf_in_ready) begin
          rx_state_d = RxCollect;
          rx_cnt_d   = '0;
        end
      end
      default: rx_state_d = RxCollect;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RxCollect;
      rx_buf_q   <= '0;
      rx_cnt_q   <= '0;
      rx_drop_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_buf_q   <= rx_buf_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_drop_q  <= rx_drop_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign bus.link_rx_ready = rx_state_q == RxCollect;
  assign bus.leaf_in_valid = rx_state_q == RxHold;
  assign bus.leaf_in_data  = rx_buf_q[HUB_FIFO_WIDTH-1:0];
  assign rx_frame_error    = rx_err_q;
  assign unused_rx_pad     = ^rx_buf_q;

  assign busy = !fifo_empty || (tx_state_q == TxSend) || (rx_cnt_q != '0) ||
                (rx_state_q == RxHold);
endmodule

// File: tb/tb_leaf_link_serdes.sv
// Randomized/directed bench for leaf_link_serdes with a queue scoreboard and
// independent TX-beat and RX-word monitors.
module tb_leaf_link_serdes;
  localparam int HW    = 20;
  localparam int LW    = 8;
  localparam int BEATS = (HW + LW - 1) / LW;

  logic clk, reset, busy, rx_frame_error;
  leaf_link_serdes_if #(.HUB_FIFO_WIDTH(HW), .LINK_WIDTH(LW)) bus ();

  leaf_link_serdes #(.HUB_FIFO_WIDTH(HW), .LINK_WIDTH(LW), .TX_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .busy           (busy),
    .rx_frame_error (rx_frame_error)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [LW:0]   exp_tx_q [$];
  logic [HW-1:0] exp_rx_q [$];

  logic          loop_mode, gate, drv_tx_ready, drv_rx_valid, drv_rx_last;
  logic [LW-1:0] drv_rx_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Link side: either directed drivers or a loopback with a random shared stall gate.
  always_comb begin
    if (loop_mode) begin
      bus.link_rx_data  = bus.link_tx_data;
      bus.link_rx_valid = bus.link_tx_valid && gate;
      bus.link_rx_last  = bus.link_tx_last;
      bus.link_tx_ready = bus.link_rx_ready && gate;
    end else begin
      bus.link_rx_data  = drv_rx_data;
      bus.link_rx_valid = drv_rx_valid;
      bus.link_rx_last  = drv_rx_last;
      bus.link_tx_ready = drv_tx_ready;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word goes out as BEATS LSB-first slices, last flag on the final slice.
  task automatic push_exp(input logic [31:0] w, input bit to_rx);
    logic [31:0] b;
    for (int k = 0; k < BEATS; k++) begin
      b = (w >> (LW * k)) & 32'hFF;
      exp_tx_q.push_back({(k == BEATS - 1), b[LW-1:0]});
    end
    if (to_rx) exp_rx_q.push_back(w[HW-1:0]);
  endtask

  task automatic send_word(input logic [31:0] w, input bit to_rx);
    int n = 0;
    while (!bus.leaf_out_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", {31'd0, bus.leaf_out_ready}, 1);
    bus.leaf_out_valid = 1'b1;
    bus.leaf_out_data  = w[HW-1:0];
    push_exp(w, to_rx);
    @(posedge clk); #1;
    bus.leaf_out_valid = 1'b0;
  endtask

  task automatic rx_beat(input logic [LW-1:0] d, input logic last);
    drv_rx_valid = 1'b1;
    drv_rx_data  = d;
    drv_rx_last  = last;
    @(posedge clk); #1;
    drv_rx_valid = 1'b0;
    drv_rx_last  = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_tx_q.size() != 0 || exp_rx_q.size() != 0) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_tx", exp_tx_q.size(), 0);
    check("drain_rx", exp_rx_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_leaf_out_ready", {31'd0, bus.leaf_out_ready}, 1);
    check("rst_link_tx_valid", {31'd0, bus.link_tx_valid}, 0);
    check("rst_link_tx_last", {31'd0, bus.link_tx_last}, 0);
    check("rst_leaf_in_valid", {31'd0, bus.leaf_in_valid}, 0);
    check("rst_link_rx_ready", {31'd0, bus.link_rx_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_frame_error", {31'd0, rx_frame_error}, 0);
  endtask

  // TX monitor: every accepted beat against the scoreboard, and stalled beats must hold.
  logic          tx_prev_stall;
  logic [LW+1:0] tx_prev_beat;
  logic [LW:0]   tx_exp;
  always @(negedge clk) begin
    if (reset) begin
      tx_prev_stall <= 1'b0;
    end else begin
      if (tx_prev_stall)
        check("tx_hold", {22'd0, bus.link_tx_valid, bus.link_tx_last, bus.link_tx_data},
              {22'd0, tx_prev_beat});
      if (bus.link_tx_valid && bus.link_tx_ready) begin
        check("tx_pending", {31'd0, exp_tx_q.size() != 0}, 1);
        if (exp_tx_q.size() != 0) begin
          tx_exp = exp_tx_q.pop_front();
          check("tx_beat", {23'd0, bus.link_tx_last, bus.link_tx_data}, {23'd0, tx_exp});
        end
      end
      tx_prev_stall <= bus.link_tx_valid && !bus.link_tx_ready;
      tx_prev_beat  <= {bus.link_tx_valid, bus.link_tx_last, bus.link_tx_data};
    end
  end

  // RX monitor: every delivered word against the scoreboard.
  logic [HW-1:0] rx_exp;
  always @(negedge clk) begin
    if (!reset && bus.leaf_in_valid && bus.leaf_in_ready) begin
      check("rx_pending", {31'd0, exp_rx_q.size() != 0}, 1);
      if (exp_rx_q.size() != 0) begin
        rx_exp = exp_rx_q.pop_front();
        check("rx_word", {12'd0, bus.leaf_in_data}, {12'd0, rx_exp});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int sent, cyc;
    reset = 1'b1;
    loop_mode = 1'b0; gate = 1'b1;
    drv_tx_ready = 1'b1; drv_rx_valid = 1'b0; drv_rx_last = 1'b0; drv_rx_data = '0;
    bus.leaf_out_valid = 1'b0; bus.leaf_out_data = '0; bus.leaf_in_ready = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single word, free-running link.
    send_word(32'hABCDE, 1'b0);
    @(posedge clk); #1;
    check("first_beat_valid", {31'd0, bus.link_tx_valid}, 1);
    check("first_beat_data", {24'd0, bus.link_tx_data}, 32'hDE);
    check("busy_while_sending", {31'd0, busy}, 1);
    wait_drain(20);
    check("busy_after_last", {31'd0, busy}, 0);

    // Fill under a stalled link: one word in the serializer plus a full FIFO.
    drv_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(32'h10000 + 32'(i * 4369), 1'b0);
    check("full_ready_low", {31'd0, bus.leaf_out_ready}, 0);
    drv_tx_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("no_gap_valid", {31'd0, bus.link_tx_valid}, 1);
    end
    @(posedge clk); #1;
    wait_drain(20);

    // RX frame held by a stalled leaf.
    bus.leaf_in_ready = 1'b0;
    exp_rx_q.push_back(20'h51234);
    rx_beat(8'h34, 1'b0);
    rx_beat(8'h12, 1'b0);
    rx_beat(8'h05, 1'b1);
    check("rx_valid_latency", {31'd0, bus.leaf_in_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      check("rx_hold_ready_low", {31'd0, bus.link_rx_ready}, 0);
      check("rx_hold_data", {12'd0, bus.leaf_in_data}, 32'h51234);
      @(posedge clk); #1;
    end
    bus.leaf_in_ready = 1'b1;
    @(posedge clk); #1;
    check("rx_ready_after_accept", {31'd0, bus.link_rx_ready}, 1);
    wait_drain(10);

    // Framing errors: early last, then missing last with flush through the next last.
    rx_beat(8'h11, 1'b0);
    rx_beat(8'h22, 1'b1);
    check("err_early_last", {31'd0, rx_frame_error}, 1);
    check("err_no_delivery", {31'd0, bus.leaf_in_valid}, 0);
    rx_beat(8'h01, 1'b0);
    rx_beat(8'h02, 1'b0);
    rx_beat(8'h03, 1'b0);
    rx_beat(8'h04, 1'b1);
    check("err_flush_no_delivery", {31'd0, bus.leaf_in_valid}, 0);
    exp_rx_q.push_back(20'hCBBAA);
    rx_beat(8'hAA, 1'b0);
    rx_beat(8'hBB, 1'b0);
    rx_beat(8'h0C, 1'b1);
    wait_drain(10);
    check("err_sticky", {31'd0, rx_frame_error}, 1);

    // Loopback with random stalls on link and leaf.
    loop_mode = 1'b1;
    sent = 0; cyc = 0;
    while ((sent < 100 || exp_tx_q.size() != 0 || exp_rx_q.size() != 0) && cyc < 5000) begin
      gate = ($urandom_range(0, 3) != 0);
      bus.leaf_in_ready = ($urandom_range(0, 3) != 0);
      if (sent < 100 && bus.leaf_out_ready && $urandom_range(0, 2) != 0) begin
        w = $urandom & 32'hFFFFF;
        bus.leaf_out_valid = 1'b1;
        bus.leaf_out_data  = w[HW-1:0];
        push_exp(w, 1'b1);
        sent++;
      end else begin
        bus.leaf_out_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.leaf_out_valid = 1'b0;
    check("loop_done_in_budget", {31'd0, cyc < 5000}, 1);
    check("loop_sent", sent, 100);
    loop_mode = 1'b0; gate = 1'b1; bus.leaf_in_ready = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of TX beat 1 and RX beat 2.
    bus.leaf_out_valid = 1'b1;
    bus.leaf_out_data  = 20'h2468A;
    push_exp(32'h2468A, 1'b0);
    @(posedge clk); #1;
    bus.leaf_out_valid = 1'b0;
    drv_rx_valid = 1'b1; drv_rx_data = 8'h01; drv_rx_last = 1'b0;
    @(posedge clk); #1;
    drv_rx_data = 8'h02;
    @(posedge clk); #1;
    drv_rx_data = 8'h03; drv_rx_last = 1'b1;
    check("mid_tx_beat1", {23'd0, bus.link_tx_last, bus.link_tx_data}, 32'h46);
    reset = 1'b1;
    exp_tx_q.delete();
    drv_rx_valid = 1'b0; drv_rx_last = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_word(32'h13579, 1'b0);
    exp_rx_q.push_back(20'hDBC9A);
    rx_beat(8'h9A, 1'b0);
    rx_beat(8'hBC, 1'b0);
    rx_beat(8'h0D, 1'b1);
    wait_drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
